// File: rtl/soma_serial_ctrl.sv
// Byte-serial wide adder/subtractor: one shared 8-bit ripple adder, one byte per clock, Start/Done handshake.
// Optional macro SOMA_SERIAL_SUB_EN enables subtraction (B inverted, initial carry 1); otherwise Sub is ignored.

module soma8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co
);
   logic [8:0] c;

   assign c[0] = ci;

   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_fa
         assign s[i]   = a[i] ^ b[i] ^ c[i];
         assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   endgenerate

   assign co = c[8];
endmodule

module soma_serial_ctrl #(
   parameter int BYTES = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic               Sub,
   input  logic               Cin,
   input  logic [8*BYTES-1:0] A,
   input  logic [8*BYTES-1:0] B,
   output logic               Busy,
   output logic               Done,
   output logic [8*BYTES-1:0] S,
   output logic               Co,
   output logic               Ovf
);
   localparam int W  = 8 * BYTES;
   localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_lat;
   logic [W-1:0]  b_lat;
   logic          carry;

   logic [7:0] a_byte;
   logic [7:0] b_byte;
   logic [7:0] sum_byte;
   logic       sum_co;

   assign a_byte = a_lat[idx*8 +: 8];
   assign b_byte = b_lat[idx*8 +: 8];

   soma8 u_soma8 (
      .a  (a_byte),
      .b  (b_byte),
      .ci (carry),
      .s  (sum_byte),
      .co (sum_co)
   );

   // Operand conditioning at Start: subtraction is A + ~B + 1.
   logic [W-1:0] b_in;
   logic         carry_in;
`ifdef SOMA_SERIAL_SUB_EN
   assign b_in     = Sub ? ~B : B;
   assign carry_in = Sub ? 1'b1 : Cin;
`else
   logic unused_sub;
   assign unused_sub = Sub;
   assign b_in       = B;
   assign carry_in   = Cin;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         a_lat <= '0;
         b_lat <= '0;
         carry <= 1'b0;
         S     <= '0;
         Co    <= 1'b0;
         Ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  a_lat <= A;
                  b_lat <= b_in;
                  carry <= carry_in;
                  idx   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               S[idx*8 +: 8] <= sum_byte;
               carry         <= sum_co;
               if (idx == LAST_IDX) begin
                  // Carry into bit 7 is recovered from the sum bit itself.
                  Co    <= sum_co;
                  Ovf   <= (a_byte[7] ^ b_byte[7] ^ sum_byte[7]) ^ sum_co;
                  idx   <= '0;
                  state <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Busy = (state == ST_RUN) || (state == ST_DONE);
   assign Done = (state == ST_DONE);
endmodule

// File: tb/tb_soma_serial_ctrl.sv
// Scoreboard bench for soma_serial_ctrl: expectations pushed on accepted Start, compared on Done.
`timescale 1ns/1ps

module tb_soma_serial_ctrl;
   localparam int BYTES = 4;
   localparam int W     = 8 * BYTES;

   logic         Clk;
   logic         Rst;
   logic         Start;
   logic         Sub;
   logic         Cin;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Busy;
   logic         Done;
   logic [W-1:0] S;
   logic         Co;
   logic         Ovf;

   soma_serial_ctrl #(.BYTES(BYTES)) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .Start (Start),
      .Sub   (Sub),
      .Cin   (Cin),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .Done  (Done),
      .S     (S),
      .Co    (Co),
      .Ovf   (Ovf)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [W-1:0] s;
      logic         co;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   n_checks    = 0;
   int   n_errors    = 0;
   int   n_accepted  = 0;
   int   n_done      = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         e;
      logic [W-1:0] bb;
      logic         c0;
      logic [W:0]   full;
      bb = b;
      c0 = cin;
`ifdef SOMA_SERIAL_SUB_EN
      if (sub) begin
         bb = ~b;
         c0 = 1'b1;
      end
`endif
      full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
      e.s   = full[W-1:0];
      e.co  = full[W];
      e.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return e;
   endfunction

   // Acceptance: Start seen while not busy is taken at this edge.
   always @(posedge Clk) begin
      if (!Rst && Start && !Busy) begin
         sb.push_back(model(A, B, Cin, Sub));
         n_accepted++;
      end
   end

   always @(negedge Clk) begin
      if (!Rst && Done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("S", 64'(S), 64'(e.s));
            chk("Co", 64'(Co), 64'(e.co));
            chk("Ovf", 64'(Ovf), 64'(e.ovf));
         end
      end
   end

   task automatic wait_idle();
      int k;
      for (k = 0; k < 50; k++) begin
         @(negedge Clk);
         if (!Busy) break;
      end
      if (k == 50) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
      int lat;
      int busy_n;
      wait_idle();
      A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      lat    = 0;
      busy_n = 0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge Clk);
         if (Busy) busy_n++;
         if (Done && lat == 0) lat = j;
         if (!Busy) break;
      end
      chk("latency", 64'(lat), 64'(BYTES + 1));
      chk("busy_cycles", 64'(busy_n), 64'(BYTES + 1));
   endtask

   initial begin
      int acc0;
      int d0;
      Rst = 1'b1; Start = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
      repeat (2) @(negedge Clk);
      chk("rst_S", 64'(S), 64'd0);
      chk("rst_Co", 64'(Co), 64'd0);
      chk("rst_Ovf", 64'(Ovf), 64'd0);
      chk("rst_Busy", 64'(Busy), 64'd0);
      chk("rst_Done", 64'(Done), 64'd0);
      Rst = 1'b0;
      @(negedge Clk);

      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
      run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

      // Start held high with operands changing every cycle.
      wait_idle();
      acc0  = n_accepted;
      Start = 1'b1;
      for (int i = 0; i < 18; i++) begin
         A   = $urandom;
         B   = $urandom;
         Cin = 1'($urandom_range(0, 1));
         Sub = 1'($urandom_range(0, 1));
         @(negedge Clk);
      end
      Start = 1'b0;
      chk("held_start_accepts", 64'(n_accepted - acc0), 64'd3);
      wait_idle();
      chk("held_sb_empty", 64'(sb.size()), 64'd0);

      // Abort during RUN at idx = 2.
      wait_idle();
      A = 32'hAAAA_AAAA; B = 32'h5555_5555; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1 Rst = 1'b1;
      #1;
      chk("abort_S", 64'(S), 64'd0);
      chk("abort_Co", 64'(Co), 64'd0);
      chk("abort_Ovf", 64'(Ovf), 64'd0);
      chk("abort_Busy", 64'(Busy), 64'd0);
      chk("abort_Done", 64'(Done), 64'd0);
      sb.delete();
      d0 = n_done;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      repeat (BYTES + 2) @(negedge Clk);
      chk("abort_no_done", 64'(n_done - d0), 64'd0);
      chk("abort_idle", 64'(Busy), 64'd0);
      run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);

      repeat (3) @(negedge Clk);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
